// File: rtl/ahb_sram_ctrl.sv
// ahb_sram_ctrl
//   AHB-Lite slave placed in front of a single-port synchronous SRAM macro.
//   Reads and writes both complete with zero wait states. A write's data
//   phase can fall in the same cycle as the next read's address phase. In
//   that case the write is parked in a one-entry posted-write buffer. The
//   buffer is written to the RAM in the next cycle that leaves the port free.
//
// Parameters
//   AW           RAM word-address width
//   DEPTH_WORDS  number of populated words; higher word indices are out of range
//
// Ports
//   HCLK, HRESET                 clock, asynchronous active-high reset
//   HSEL/HADDR/HTRANS/HWRITE/
//   HSIZE/HWDATA/HREADY          AHB-Lite slave inputs
//   HRDATA/HREADYOUT/HRESP       AHB-Lite slave outputs
//   RAM_EN/RAM_WE/RAM_A/RAM_Di   SRAM macro controls (Do valid one cycle after a read)
//   RAM_Do                       SRAM macro read data
//
// Build option
//   AHB_SRAM_RANGE_ERR_EN  when defined, an out-of-range access gets a
//                          two-cycle ERROR response. Otherwise out-of-range
//                          reads return zero, out-of-range writes are dropped,
//                          and HRESP is tied low.

module ahb_sram_ctrl #(
    parameter int AW          = 12,
    parameter int DEPTH_WORDS = 3072
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          HSEL,
    input  logic [31:0]   HADDR,
    input  logic [1:0]    HTRANS,
    input  logic          HWRITE,
    input  logic [2:0]    HSIZE,
    input  logic [31:0]   HWDATA,
    input  logic          HREADY,
    output logic [31:0]   HRDATA,
    output logic          HREADYOUT,
    output logic          HRESP,
    output logic          RAM_EN,
    output logic [3:0]    RAM_WE,
    output logic [AW-1:0] RAM_A,
    output logic [31:0]   RAM_Di,
    input  logic [31:0]   RAM_Do
);

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH_WORDS);

    // Address-phase decode
    logic          acc;
    logic [AW-1:0] ap_idx;
    logic          ap_in_range;
    logic [3:0]    ap_be;
    logic          rd_ap;

    assign acc         = HSEL & HTRANS[1] & HREADY;
    assign ap_idx      = HADDR[AW+1:2];
    assign ap_in_range = ({1'b0, ap_idx} < DEPTH_L);
    assign rd_ap       = acc & ~HWRITE & ap_in_range;

    always_comb begin
        case (HSIZE)
            3'd0:    ap_be = 4'b0001 << HADDR[1:0];
            3'd1:    ap_be = 4'b0011 << {HADDR[1], 1'b0};
            default: ap_be = 4'b1111;
        endcase
    end

    // Data-phase and posted-write buffer state
    logic          dp_read_q,  dp_read_d;
    logic          dp_write_q, dp_write_d;
    logic [AW-1:0] dp_addr_q,  dp_addr_d;
    logic [3:0]    dp_be_q,    dp_be_d;
    logic          wb_valid_q, wb_valid_d;
    logic [AW-1:0] wb_addr_q,  wb_addr_d;
    logic [3:0]    wb_be_q,    wb_be_d;
    logic [31:0]   wb_data_q,  wb_data_d;

    logic          ram_en;
    logic [3:0]    ram_we;

    always_comb begin
        dp_read_d  = dp_read_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        dp_be_d    = dp_be_q;
        wb_valid_d = wb_valid_q;
        wb_addr_d  = wb_addr_q;
        wb_be_d    = wb_be_q;
        wb_data_d  = wb_data_q;
        ram_en     = 1'b0;
        ram_we     = 4'b0000;
        RAM_A      = '0;
        RAM_Di     = 32'h0;

        // Out-of-range transfers never open a data phase. That one rule gives
        // both "read returns zero" and "write dropped / no RAM access".
        if (HREADY) begin
            dp_read_d  = rd_ap;
            dp_write_d = acc & HWRITE & ap_in_range;
            dp_addr_d  = ap_idx;
            dp_be_d    = ap_be;
        end

        // Port priority: read address phase, then direct write, then drain.
        if (rd_ap) begin
            ram_en = 1'b1;
            RAM_A  = ap_idx;
            if (dp_write_q) begin
                wb_valid_d = 1'b1;
                wb_addr_d  = dp_addr_q;
                wb_be_d    = dp_be_q;
                wb_data_d  = HWDATA;
            end
        end else if (dp_write_q) begin
            ram_en = 1'b1;
            ram_we = dp_be_q;
            RAM_A  = dp_addr_q;
            RAM_Di = HWDATA;
        end else if (wb_valid_q) begin
            ram_en     = 1'b1;
            ram_we     = wb_be_q;
            RAM_A      = wb_addr_q;
            RAM_Di     = wb_data_q;
            wb_valid_d = 1'b0;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            dp_read_q  <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= '0;
            dp_be_q    <= 4'b0000;
            wb_valid_q <= 1'b0;
            wb_addr_q  <= '0;
            wb_be_q    <= 4'b0000;
            wb_data_q  <= 32'h0;
        end else begin
            dp_read_q  <= dp_read_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            dp_be_q    <= dp_be_d;
            wb_valid_q <= wb_valid_d;
            wb_addr_q  <= wb_addr_d;
            wb_be_q    <= wb_be_d;
            wb_data_q  <= wb_data_d;
        end
    end

    // The macro must stay idle for as long as reset is held.
    assign RAM_EN = ram_en & ~HRESET;
    assign RAM_WE = HRESET ? 4'b0000 : ram_we;

    // Read data. A write posted during this read's address phase has not
    // reached the RAM yet, so its lanes are forwarded from the buffer.
    logic fwd_hit;
    assign fwd_hit = wb_valid_q & (wb_addr_q == dp_addr_q);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign HRDATA[8*gi +: 8] = !dp_read_q ? 8'h00 :
                                       (fwd_hit & wb_be_q[gi]) ? wb_data_q[8*gi +: 8] :
                                       RAM_Do[8*gi +: 8];
        end
    endgenerate

`ifdef AHB_SRAM_RANGE_ERR_EN
    typedef enum logic [1:0] {ST_OKAY, ST_ERR1, ST_ERR2} err_state_t;
    err_state_t err_state_q, err_state_d;

    always_comb begin
        err_state_d = err_state_q;
        case (err_state_q)
            ST_OKAY, ST_ERR2: err_state_d = (acc & ~ap_in_range) ? ST_ERR1 : ST_OKAY;
            ST_ERR1:          err_state_d = ST_ERR2;
            default:          err_state_d = ST_OKAY;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) err_state_q <= ST_OKAY;
        else        err_state_q <= err_state_d;
    end

    assign HREADYOUT = (err_state_q != ST_ERR1);
    assign HRESP     = (err_state_q != ST_OKAY);
`else
    assign HREADYOUT = 1'b1;
    assign HRESP     = 1'b0;
`endif

    // Upper address bits and HTRANS[0] carry no meaning for this slave.
    logic unused_ok;
    assign unused_ok = ^{HADDR[31:AW+2], HTRANS[0]};

endmodule
